// File: rtl/clk_mon_pkg.sv
// Shared definitions for the slow-clock divider/monitor pair: counter width,
// nominal half-period and monitor state encoding.
package clk_mon_pkg;

    localparam int CNT_W            = 29;
    localparam int NOMINAL_HALF_DEF = 6_800_000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for the asynchronous slow clock, plus a history flop
// so edges are detected one cycle after the level is considered stable.
module sync_edge_det (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic i_async,
    output logic o_edge,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_edge = r_sync2 ^ r_hist;
    assign o_rise = r_sync2 & ~r_hist;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock receiver: edge enables, half-period measurement and lock qualification.
// Define CLK_MON_WATCHDOG_EN to enable the stall timeout into LOST.
//
//   state   | meaning
//   IDLE    | after reset, waiting for the first edge (not judged)
//   ACQUIRE | counting consecutive in-window half-periods
//   LOCKED  | LOCK_COUNT good half-periods seen in a row
//   LOST    | input stalled; next edge restarts acquisition unjudged
module slow_clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int NOMINAL_HALF = NOMINAL_HALF_DEF,
    parameter int TOL_CYCLES   = 68000,
    parameter int LOCK_COUNT   = 4
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             clk_slow_in,
    output logic             tick,
    output logic             half_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             lost,
    output logic             period_err
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    // Window bounds precomputed so the in-window test is two unsigned compares.
    localparam logic [CNT_W-1:0] LO_BOUND =
        (TOL_CYCLES >= NOMINAL_HALF) ? '0 : CNT_W'(NOMINAL_HALF - TOL_CYCLES);
    localparam logic [CNT_W-1:0] HI_BOUND    = CNT_W'(NOMINAL_HALF + TOL_CYCLES);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);

    logic              w_edge;
    logic              w_rise;
    logic [CNT_W-1:0]  w_meas;
    logic              w_in_win;
    logic              w_timeout;

    logic [CNT_W-1:0]  r_cnt;
    logic [GOOD_W-1:0] r_good;
    state_t            r_state;

    sync_edge_det u_sync (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .i_async (clk_slow_in),
        .o_edge  (w_edge),
        .o_rise  (w_rise)
    );

    assign w_meas   = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
    assign w_in_win = (w_meas >= LO_BOUND) && (w_meas <= HI_BOUND);

`ifdef CLK_MON_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * NOMINAL_HALF);
    assign w_timeout = (r_cnt >= TIMEOUT) && ((r_state == ACQUIRE) || (r_state == LOCKED));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_good      <= '0;
            r_state     <= IDLE;
            half_period <= '0;
            tick        <= 1'b0;
            half_tick   <= 1'b0;
            locked      <= 1'b0;
            lost        <= 1'b0;
            period_err  <= 1'b0;
        end else begin
            tick       <= w_rise;
            half_tick  <= w_edge;
            period_err <= 1'b0;
            if (w_edge) begin
                // An edge always wins over a coincident timeout.
                half_period <= w_meas;
                r_cnt       <= '0;
                case (r_state)
                    IDLE, LOST: begin
                        r_state <= ACQUIRE;
                        r_good  <= '0;
                        locked  <= 1'b0;
                        lost    <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (w_in_win) begin
                            r_good <= r_good + 1'b1;
                            if (r_good == GOOD_LAST) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_good <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_in_win) begin
                            period_err <= 1'b1;
                            r_good     <= '0;
                            r_state    <= ACQUIRE;
                            locked     <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else begin
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;
                if (w_timeout) begin
                    r_state <= LOST;
                    r_good  <= '0;
                    locked  <= 1'b0;
                    lost    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with an edge-timestamp reference model.
// Works with and without CLK_MON_WATCHDOG_EN defined.
module tb_slow_clk_monitor;

    localparam int NOM   = 10;
    localparam int TOL   = 1;
    localparam int LOCKN = 4;
`ifdef CLK_MON_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_slow_in = 1'b0;
    logic        tick, half_tick, locked, lost, period_err;
    logic [28:0] half_period;

    slow_clk_monitor #(
        .NOMINAL_HALF (NOM),
        .TOL_CYCLES   (TOL),
        .LOCK_COUNT   (LOCKN)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .clk_slow_in (clk_slow_in),
        .tick        (tick),
        .half_tick   (half_tick),
        .half_period (half_period),
        .locked      (locked),
        .lost        (lost),
        .period_err  (period_err)
    );

    always #10 clk_50m = ~clk_50m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int perr_pulses = 0;

    // Model: each input toggle becomes an output event 3 cycles later; a
    // half-period is the distance between consecutive output events.
    int due_q[$];
    bit lvl_q[$];
    int last_edge = 0;
    int good = 0;
    int meas = 0;
    bit seen = 0;
    bit e_locked = 0, e_lost = 0, e_tick = 0, e_ht = 0, e_perr = 0;
    int e_hp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_50m) begin
        cyc++;
        e_tick = 0;
        e_ht = 0;
        e_perr = 0;
        if (!rst_n) begin
            seen = 0; e_locked = 0; e_lost = 0; good = 0; e_hp = 0;
            last_edge = cyc;
            due_q.delete();
            lvl_q.delete();
            if (clk_slow_in) begin
                due_q.push_back(cyc + 3);
                lvl_q.push_back(1'b1);
            end
        end else if (due_q.size() > 0 && due_q[0] == cyc) begin
            e_ht = 1;
            e_tick = lvl_q.pop_front();
            void'(due_q.pop_front());
            meas = cyc - last_edge;
            if (meas > 29'h1FFF_FFFF) meas = 29'h1FFF_FFFF;
            last_edge = cyc;
            e_hp = meas;
            if (!seen) begin
                seen = 1; good = 0; e_locked = 0; e_lost = 0;
            end else if (meas >= NOM - TOL && meas <= NOM + TOL) begin
                if (!e_locked) begin
                    good++;
                    if (good >= LOCKN) e_locked = 1;
                end
            end else begin
                if (e_locked) e_perr = 1;
                e_locked = 0;
                good = 0;
            end
        end else if (WD && seen && (cyc - last_edge >= 2 * NOM + 1)) begin
            seen = 0; e_lost = 1; e_locked = 0; good = 0;
        end
    end

    always @(negedge clk_50m) begin
        if (cyc > 0) begin
            chk("tick", tick, e_tick);
            chk("half_tick", half_tick, e_ht);
            chk("half_period", 32'(half_period), e_hp);
            chk("locked", locked, e_locked);
            chk("lost", lost, e_lost);
            chk("period_err", period_err, e_perr);
            if (period_err === 1'b1) perr_pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic toggle();
        clk_slow_in = ~clk_slow_in;
        due_q.push_back(cyc + 3);
        lvl_q.push_back(clk_slow_in);
    endtask

    task automatic half(input int n);
        toggle();
        step(n);
    endtask

    int perr_base;

    initial begin
        rst_n = 1'b0;
        clk_slow_in = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(5);

        // Acquire from IDLE with 10-cycle halves
        chk("idle_locked", locked, 0);
        toggle();
        step(2); chk("tick_lat2", tick, 0);
        step(1); chk("tick_lat3", tick, 1); chk("ht_lat3", half_tick, 1);
        step(1); chk("tick_1cyc", tick, 0);
        step(6);
        repeat (3) half(10);
        chk("unlocked_4th", locked, 0);
        toggle();
        step(3); chk("lock_5th", locked, 1); chk("hp_10", 32'(half_period), 10);
        step(7);

        // One long half-period while locked
        half(13);
        toggle();
        step(3);
        chk("perr_13", period_err, 1); chk("hp_13", 32'(half_period), 13); chk("unlock_13", locked, 0);
        step(1); chk("perr_1cyc", period_err, 0);
        step(6);
        repeat (3) half(10);
        chk("relock_pre", locked, 0);
        half(10);
        chk("relock", locked, 1);

        // Reset, then alternating 9/11 halves
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        chk("rst_locked", locked, 0); chk("rst_hp", 32'(half_period), 0);
        step(5);
        perr_base = perr_pulses;
        repeat (5) begin
            half(9);
            half(11);
        end
        chk("alt_locked", locked, 1);
        chk("alt_no_perr", perr_pulses - perr_base, 0);

        // Stall for 25 cycles while locked
        toggle();
        step(23); chk("stall_lost_early", lost, 0);
        step(1);  chk("stall_lost", lost, WD ? 1 : 0); chk("stall_locked", locked, WD ? 0 : 1);
        step(1);
        toggle();
        step(3);
        chk("stall_hp", 32'(half_period), 25);
        chk("stall_perr", period_err, WD ? 0 : 1);
        chk("stall_lost_clr", lost, 0);
        chk("stall_unlock", locked, 0);
        step(7);
        repeat (4) half(10);
        chk("stall_relock", locked, 1);

        // Reset for one cycle while locked with the input high
        if (!clk_slow_in) half(10);
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        chk("r1_tick", tick, 0); chk("r1_ht", half_tick, 0); chk("r1_locked", locked, 0);
        chk("r1_lost", lost, 0); chk("r1_perr", period_err, 0); chk("r1_hp", 32'(half_period), 0);
        step(2); chk("r1_ht_early", half_tick, 0);
        step(1); chk("r1_tick3", tick, 1); chk("r1_hp3", 32'(half_period), 3);
        repeat (5) half(10);
        chk("r1_relock", locked, 1);
        step(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
